// File: rtl/fifo_sync_param.sv
// Purpose : parametrised synchronous FIFO with exact occupancy, runtime almost-empty/almost-full
//           thresholds, one-cycle overflow/underflow pulses and a sticky error flag.
// Latency : pop data registered, valid_out the cycle after an accepted rd_en; flags track fill_level.
// Backpressure: pushes at full (without a pop) and pops at empty are rejected, never corrupting state.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   data_in, wr_en        - push data and request
//   rd_en                 - pop request
//   ae_thr, af_thr        - almost-empty / almost-full thresholds (0 / >=DEPTH disable them)
//   err_clr               - clears error_flag
//   data_out, valid_out   - registered pop data and its one-cycle qualifier
//   fill_level            - current occupancy (0..DEPTH)
//   empty/full/almost_*   - registered status flags, consistent with fill_level every cycle
//   overflow/underflow    - one-cycle pulses after a rejected push / pop
//   error_flag            - sticky, set by any rejection, cleared by err_clr
module fifo_sync_param #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 10,
    parameter int PTR_SIZE = $clog2(DEPTH),
    parameter int CNT_SIZE = PTR_SIZE + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [CNT_SIZE-1:0] ae_thr,
    input  logic [CNT_SIZE-1:0] af_thr,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    data_out,
    output logic                valid_out,
    output logic [CNT_SIZE-1:0] fill_level,
    output logic                empty_flag,
    output logic                full_flag,
    output logic                almost_empty_flag,
    output logic                almost_full_flag,
    output logic                overflow_flag,
    output logic                underflow_flag,
    output logic                error_flag
);

    localparam logic [CNT_SIZE-1:0] DEPTH_CNT = CNT_SIZE'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_SIZE-1:0] wr_ptr;
    logic [PTR_SIZE-1:0] rd_ptr;
    logic [CNT_SIZE-1:0] count;
    logic [CNT_SIZE-1:0] count_next;
    logic                pop_ok;
    logic                push_ok;
    logic                push_rej;
    logic                pop_rej;

    // A push at full is still legal when a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok     = rd_en && (count != '0);
        push_ok    = wr_en && ((count != DEPTH_CNT) || pop_ok);
        push_rej   = wr_en && !push_ok;
        pop_rej    = rd_en && !pop_ok;
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_SIZE'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - CNT_SIZE'(1);
        end
    end

    assign fill_level = count;

    // Storage is never reset; a push during reset is dropped.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            data_out          <= '0;
            valid_out         <= 1'b0;
            empty_flag        <= 1'b1;
            full_flag         <= 1'b0;
            almost_empty_flag <= 1'b0;
            almost_full_flag  <= 1'b0;
            overflow_flag     <= 1'b0;
            underflow_flag    <= 1'b0;
            error_flag        <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_SIZE'(1);
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + PTR_SIZE'(1);
                data_out <= mem[rd_ptr];
            end
            valid_out <= pop_ok;
            count     <= count_next;

            // Flags come from count_next so they line up with fill_level.
            empty_flag        <= (count_next == '0);
            full_flag         <= (count_next == DEPTH_CNT);
            almost_empty_flag <= (count_next != '0) && (count_next <= ae_thr);
            almost_full_flag  <= (count_next >= af_thr) && (count_next < DEPTH_CNT);

            overflow_flag  <= push_rej;
            underflow_flag <= pop_rej;

            // A fresh rejection outranks a simultaneous clear.
            if (push_rej || pop_rej) begin
                error_flag <= 1'b1;
            end else if (err_clr) begin
                error_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

    localparam int DEPTH = 8;
    localparam int WIDTH = 10;
    localparam int CNT   = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [CNT-1:0]   ae_thr;
    logic [CNT-1:0]   af_thr;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic [CNT-1:0]   fill_level;
    logic             empty_flag;
    logic             full_flag;
    logic             almost_empty_flag;
    logic             almost_full_flag;
    logic             overflow_flag;
    logic             underflow_flag;
    logic             error_flag;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q [$];   // words the monitor must see next
    logic [WIDTH-1:0] mdl_q [$];   // words currently stored

    fifo_sync_param #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .wr_en            (wr_en),
        .rd_en            (rd_en),
        .ae_thr           (ae_thr),
        .af_thr           (af_thr),
        .err_clr          (err_clr),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .fill_level       (fill_level),
        .empty_flag       (empty_flag),
        .full_flag        (full_flag),
        .almost_empty_flag(almost_empty_flag),
        .almost_full_flag (almost_full_flag),
        .overflow_flag    (overflow_flag),
        .underflow_flag   (underflow_flag),
        .error_flag       (error_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // {fill_level, empty, full, almost_empty, almost_full}
    task automatic chk_st(input string name, input int fill, input logic e, input logic f,
                          input logic ae, input logic af);
        chk(name, {fill_level, empty_flag, full_flag, almost_empty_flag, almost_full_flag},
            {CNT'(fill), e, f, ae, af});
    endtask

    // One clock with the given requests; expected pop data is queued after the edge.
    task automatic do_op(input logic wr, input logic rd, input logic [WIDTH-1:0] d,
                         input logic clr);
        logic pop_acc;
        logic push_acc;
        pop_acc  = rd && (mdl_q.size() != 0);
        push_acc = wr && ((mdl_q.size() != DEPTH) || pop_acc);
        wr_en    = wr;
        rd_en    = rd;
        data_in  = d;
        err_clr  = clr;
        @(posedge clk);
        if (pop_acc) exp_q.push_back(mdl_q.pop_front());
        if (push_acc) mdl_q.push_back(d);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset(input logic wr, input logic [WIDTH-1:0] d);
        reset   = 1'b1;
        wr_en   = wr;
        data_in = d;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        mdl_q.delete();
    endtask

    // Monitor: every valid_out must match the oldest expected word, and every expected word must show.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end else if (exp_q.size() != 0) begin
            chk("missing_valid", 32'(valid_out), 32'd1);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [8:0] ae_tab;
        logic [8:0] af_tab;
        ae_tab  = 9'b000000110;  // counts 1..2
        af_tab  = 9'b011000000;  // counts 6..7
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        data_in = '0;
        ae_thr  = 4'd2;
        af_thr  = 4'd6;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        do_op(1'b0, 1'b0, '0, 1'b0);

        // Reset / idle state
        chk_st("reset_status", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_pulses_err_valid", {overflow_flag, underflow_flag, error_flag, valid_out}, 4'b0000);
        chk("reset_data_out", 32'(data_out), 32'd0);

        // Fill 1..8 then drain, with flag table per occupancy
        for (int i = 1; i <= DEPTH; i++) begin
            do_op(1'b1, 1'b0, WIDTH'(i), 1'b0);
            chk_st($sformatf("fill_%0d", i), i, 1'b0, i == DEPTH, ae_tab[i], af_tab[i]);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            do_op(1'b0, 1'b1, '0, 1'b0);
            chk_st($sformatf("drain_%0d", i), DEPTH - i, i == DEPTH, 1'b0,
                   ae_tab[DEPTH - i], af_tab[DEPTH - i]);
        end
        do_op(1'b0, 1'b0, '0, 1'b0);

        // Overflow at full
        for (int i = 1; i <= DEPTH; i++) do_op(1'b1, 1'b0, WIDTH'(i), 1'b0);
        do_op(1'b1, 1'b0, 10'h3FF, 1'b0);
        chk("ovf_pulse_err", {overflow_flag, underflow_flag, error_flag}, 3'b101);
        chk_st("ovf_fill", 8, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, '0, 1'b0);   // pops 0x001
        chk("ovf_pulse_gone_err_held", {overflow_flag, error_flag}, 2'b01);
        do_op(1'b0, 1'b0, '0, 1'b1);
        chk("err_clr", 32'(error_flag), 32'd0);

        // Simultaneous push/pop at full across pointer wrap
        do_op(1'b1, 1'b0, 10'h009, 1'b0);
        chk_st("refill", 8, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            do_op(1'b1, 1'b1, WIDTH'(10'h100 + i), 1'b0);
            chk_st($sformatf("full_rw_%0d", i), 8, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("full_rw_no_pulses", {overflow_flag, underflow_flag, error_flag}, 3'b000);
        for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b1, '0, 1'b0);
        do_op(1'b0, 1'b0, '0, 1'b0);
        chk_st("drained", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Empty with push+pop: push only, underflow pulse
        do_op(1'b1, 1'b1, 10'h155, 1'b0);
        chk("empty_rw_pulses_valid", {underflow_flag, overflow_flag, valid_out, error_flag}, 4'b1001);
        chk_st("empty_rw_fill", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Rejection in the same cycle as err_clr keeps the error set
        do_op(1'b0, 1'b1, '0, 1'b1);   // pops 0x155
        do_op(1'b0, 1'b1, '0, 1'b1);   // empty pop + clear
        chk("err_clr_loses", {underflow_flag, error_flag}, 2'b11);
        do_op(1'b0, 1'b0, '0, 1'b1);
        chk("err_clr_after", 32'(error_flag), 32'd0);

        // Reset mid-operation with a push in the same cycle
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, WIDTH'(10'h050 + i), 1'b0);
        chk_st("fill_5", 5, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset(1'b1, 10'h2AA);
        chk_st("mid_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, '0, 1'b0);
        chk("post_reset_pop_rejected", {underflow_flag, valid_out, error_flag}, 3'b101);
        chk_st("post_reset_fill", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        do_op(1'b0, 1'b0, '0, 1'b0);
        do_op(1'b0, 1'b0, '0, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
